// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between uart_rx and the CPU UART data/handshake registers.
// Bytes are drained from uart_rx over a level handshake (in_ready / in_clear) and
// stored in a circular FIFO. The head byte and a non-empty flag are presented to the
// CPU read mux. The CPU pops with a read strobe (rd_ack) from a foreign clock domain.
// Head outputs (out_ready/out_data) lag the FIFO state by one sys_clk edge.

module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  sys_clk,
    input  logic                  RESET_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_ready,
    output logic                  in_clear,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_ready,
    input  logic                  rd_ack,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int                  DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

    // Ingest handshake state: IDLE waits for a byte, CLEAR waits for uart_rx to drop in_ready.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ingest_t;

    ingest_t                 state;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;

    // rd_ack synchronizer (s1, s2) and history flop (s3) for rising-edge detection.
    logic                    ack_s1;
    logic                    ack_s2;
    logic                    ack_s3;

    logic                    pop_req;
    logic                    pop_eff;
    logic                    push_try;
    logic                    push_acc;
    logic                    push_drop;

    // A pop request is the first cycle the synchronized strobe is seen high.
    assign pop_req   = ack_s2 & ~ack_s3;
    // Popping an empty FIFO is a no-op.
    assign pop_eff   = pop_req && (count != CNT_ZERO);
    // One push attempt per in_ready assertion: only IDLE samples a new byte.
    assign push_try  = (state == ST_IDLE) && in_ready;
    // A full FIFO still accepts a byte when a pop frees the slot on the same edge.
    assign push_acc  = push_try && ((count != CNT_FULL) || pop_eff);
    assign push_drop = push_try && !push_acc;

    // Bring the asynchronous CPU read strobe into sys_clk and keep one cycle of history.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values; a blocking chain here would collapse the synchronizer.
        if (!RESET_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
            ack_s3 <= 1'b0;
        end else begin
            ack_s1 <= rd_ack;
            ack_s2 <= ack_s1;
            ack_s3 <= ack_s2;
        end
    end

    // Byte storage; writes are suppressed while reset is asserted.
    always_ff @(posedge sys_clk) begin
        // NOTE: the storage array is deliberately not reset; count/pointers define
        // which entries are valid, so stale contents are never observed.
        if (RESET_n && push_acc) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Ingest FSM, pointers, occupancy, sticky overflow and registered head outputs.
    always_ff @(posedge sys_clk) begin
        if (!RESET_n) begin
            state     <= ST_IDLE;
            in_clear  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            out_ready <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_ready) begin
                        in_clear <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (!in_ready) begin
                        in_clear <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    in_clear <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase

            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            // Simultaneous accepted push and effective pop leave occupancy unchanged.
            if (push_acc && !pop_eff) begin
                count <= count + CNT_ONE;
            end else if (pop_eff && !push_acc) begin
                count <= count - CNT_ONE;
            end

            // A drop on the same edge as ovf_clr keeps the flag set.
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            // Head view follows the settled FIFO state one edge later, so a freshly
            // written entry is already in mem when it is presented.
            out_ready <= (count != CNT_ZERO);
            if (count != CNT_ZERO) begin
                out_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.

module tb_uart_rx_fifo;

    logic        sys_clk  = 1'b0;
    logic        RESET_n  = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready = 1'b0;
    logic        in_clear;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        rd_ack   = 1'b0;
    logic [4:0]  count;
    logic        overflow;
    logic        ovf_clr  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .DATA_W     (8)
    ) dut (
        .sys_clk   (sys_clk),
        .RESET_n   (RESET_n),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .in_clear  (in_clear),
        .out_data  (out_data),
        .out_ready (out_ready),
        .rd_ack    (rd_ack),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "time limit reached");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full handshake with bounded waits on in_clear.
    task automatic push_byte(input logic [7:0] b);
        int n;
        in_data  = b;
        in_ready = 1'b1;
        n = 0;
        tick();
        while (in_clear !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check("push_ack", 32'(in_clear), 32'd1);
        in_ready = 1'b0;
        n = 0;
        tick();
        while (in_clear !== 1'b0 && n < 8) begin
            tick();
            n++;
        end
        check("push_release", 32'(in_clear), 32'd0);
    endtask

    // rd_ack high 2 cycles, low 3: pop lands on edge 3, head view on edge 4.
    task automatic pop_pulse();
        rd_ack = 1'b1;
        tick();
        tick();
        rd_ack = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        check({tag, "_ready"}, 32'(out_ready), 32'd1);
        check(tag, 32'(out_data), 32'(exp));
        pop_pulse();
    endtask

    initial begin
        // Reset state
        RESET_n = 1'b0;
        repeat (3) tick();
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_ready", 32'(out_ready), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_clear",  32'(in_clear),  32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        RESET_n = 1'b1;
        tick();

        // 1: single byte handshake and head presentation
        in_data  = 8'h41;
        in_ready = 1'b1;
        tick();
        check("t1_clear_rise", 32'(in_clear), 32'd1);
        check("t1_count",      32'(count),    32'd1);
        in_ready = 1'b0;
        tick();
        check("t1_clear_fall", 32'(in_clear),  32'd0);
        check("t1_out_ready",  32'(out_ready), 32'd1);
        check("t1_out_data",   32'(out_data),  32'h41);
        read_expect("t1_read", 8'h41);
        check("t1_empty_count", 32'(count),     32'd0);
        check("t1_empty_ready", 32'(out_ready), 32'd0);

        // 2: long in_ready gives exactly one push
        in_data  = 8'h55;
        in_ready = 1'b1;
        repeat (20) tick();
        check("t2_clear_held", 32'(in_clear), 32'd1);
        check("t2_count_held", 32'(count),    32'd1);
        in_ready = 1'b0;
        tick();
        tick();
        check("t2_count",      32'(count),    32'd1);
        check("t2_clear_fall", 32'(in_clear), 32'd0);
        read_expect("t2_read", 8'h55);
        check("t2_empty", 32'(count), 32'd0);

        // 3: fill, drop with concurrent ovf_clr (set wins), drain, clear
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
        end
        check("t3_full",        32'(count),    32'd16);
        check("t3_no_ovf_yet",  32'(overflow), 32'd0);
        in_data  = 8'hAA;
        in_ready = 1'b1;
        ovf_clr  = 1'b1;
        tick();
        ovf_clr  = 1'b0;
        check("t3_ovf_set_wins", 32'(overflow), 32'd1);
        check("t3_drop_ack",     32'(in_clear), 32'd1);
        in_ready = 1'b0;
        tick();
        check("t3_drop_release", 32'(in_clear), 32'd0);
        check("t3_still_full",   32'(count),    32'd16);
        for (int i = 0; i < 16; i++) begin
            read_expect("t3_read", 8'(i));
        end
        check("t3_drained_ready", 32'(out_ready), 32'd0);
        check("t3_drained_count", 32'(count),     32'd0);
        check("t3_ovf_sticky",    32'(overflow),  32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_cleared",   32'(overflow),  32'd0);

        // 4: advance pointers, then wrap wr_ptr
        for (int i = 0; i < 10; i++) begin
            push_byte(8'h10 + 8'(i));
            read_expect("t4_pp", 8'h10 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            push_byte(8'h20 + 8'(i));
        end
        check("t4_count10", 32'(count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            read_expect("t4_wrap_read", 8'h20 + 8'(i));
        end
        check("t4_empty", 32'(count), 32'd0);

        // 5: push into a full FIFO on the same edge as a synchronized pop
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h30 + 8'(i));
        end
        check("t5_full", 32'(count),    32'd16);
        check("t5_head", 32'(out_data), 32'h30);
        rd_ack = 1'b1;
        tick();
        tick();
        rd_ack   = 1'b0;
        in_data  = 8'h77;
        in_ready = 1'b1;
        tick();
        check("t5_count_stays", 32'(count),    32'd16);
        check("t5_ack",         32'(in_clear), 32'd1);
        check("t5_no_ovf",      32'(overflow), 32'd0);
        in_ready = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 16; i++) begin
            read_expect("t5_read", 8'h30 + 8'(i));
        end
        read_expect("t5_read_last", 8'h77);
        check("t5_empty",    32'(count),    32'd0);
        check("t5_ovf_zero", 32'(overflow), 32'd0);

        // 6: pop on empty is ignored; head byte holds
        pop_pulse();
        check("t6_count",    32'(count),     32'd0);
        check("t6_ready",    32'(out_ready), 32'd0);
        check("t6_data_hold", 32'(out_data), 32'h77);

        // 6: reset taken in CLEAR with 3 bytes stored
        push_byte(8'hA1);
        push_byte(8'hA2);
        in_data  = 8'hA3;
        in_ready = 1'b1;
        tick();
        check("t6_count3", 32'(count),    32'd3);
        check("t6_in_clr", 32'(in_clear), 32'd1);
        RESET_n = 1'b0;
        tick();
        check("t6_rst_count", 32'(count),     32'd0);
        check("t6_rst_ready", 32'(out_ready), 32'd0);
        check("t6_rst_data",  32'(out_data),  32'd0);
        check("t6_rst_clear", 32'(in_clear),  32'd0);
        in_ready = 1'b0;
        RESET_n  = 1'b1;
        tick();
        tick();
        check("t6_post_count", 32'(count),     32'd0);
        check("t6_post_ready", 32'(out_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
